// File: rtl/mem_grant_sequencer.sv
// ---------------------------------------------------------------------------
// mem_grant_sequencer
//
// Purpose:
//   Downstream stage of a fixed-priority request arbiter.
//   - Forwards the requester valids to the arbiter as its request vector.
//   - Captures the arbiter's one-hot grant and locks ownership for the
//     winner's whole burst.
//   - Muxes the owner's address and write data onto a single memory request
//     port that uses a valid/ready handshake.
//   - Releases the lock after the last beat is accepted.
//   One IDLE cycle always separates two bursts.
//
// Parameters:
//   N   number of requesters (matches the arbiter)
//   AW  word address width
//   DW  data width
//   LW  burst length field width; req_len = beats-1
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester pending burst, held until its last beat is accepted
//   req_addr     per-requester base word address, slice i = [i*AW +: AW]
//   req_we       per-requester write flag (1 = write burst)
//   req_len      per-requester beats-1, slice i = [i*LW +: LW]
//   req_wdata    per-requester current write beat, slice i = [i*DW +: DW]
//   req_ready    one-hot per-beat accept pulse to the owner
//   arb_request  request vector to the arbiter
//   arb_grant    grant vector from the arbiter (one-hot or zero)
//   mem_valid    memory beat valid
//   mem_addr     base + beat index (wraps mod 2^AW)
//   mem_we       latched owner write flag
//   mem_wdata    owner's req_wdata, passed through combinationally
//   mem_ready    memory accepts the beat when mem_valid & mem_ready
//   busy         high while a burst is owned
//   owner        latched one-hot owner, zero when idle
//
// Configuration:
//   MEM_GRANT_FAIR_EN  when defined, the last completed owner is masked from
//                      the arbiter request while any other requester waits,
//                      so a high-priority requester cannot win back-to-back.
//                      Undefined (default): pure fixed priority.
// ---------------------------------------------------------------------------
module mem_grant_sequencer #(
  parameter int N  = 10,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*AW-1:0]   req_addr,
  input  logic [N-1:0]      req_we,
  input  logic [N*LW-1:0]   req_len,
  input  logic [N*DW-1:0]   req_wdata,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      arb_request,
  input  logic [N-1:0]      arb_grant,
  output logic              mem_valid,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [N-1:0]      owner
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   base;
  logic [LW-1:0]   len;
  logic [LW-1:0]   beat_cnt;
  logic            we_q;

  // Grant decode
  logic            grant_onehot;
  logic [AW-1:0]   grant_addr;
  logic [LW-1:0]   grant_len;
  logic            grant_we;

  // Owner mux
  logic            owner_valid;
  logic [DW-1:0]   owner_wdata;

  logic            beat_fire;
  logic            last_beat;
  logic [N-1:0]    idle_request;

`ifdef MEM_GRANT_FAIR_EN
  logic [N-1:0]    last_owner;
  logic [N-1:0]    others_valid;
`endif

  // A grant is only honoured when exactly one bit is set; x & (x-1) clears
  // the lowest set bit, so a non-zero x with nothing left is one-hot.
  always_comb begin
    grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
    grant_addr   = '0;
    grant_len    = '0;
    grant_we     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) begin
        grant_addr = grant_addr | req_addr[i*AW +: AW];
        grant_len  = grant_len  | req_len[i*LW +: LW];
        grant_we   = grant_we   | req_we[i];
      end
    end
  end

  // AND-OR mux keyed by the one-hot owner register; owner is zero in IDLE,
  // so nothing leaks onto the memory port between bursts.
  always_comb begin
    owner_valid = 1'b0;
    owner_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (owner[i]) begin
        owner_valid = owner_valid | req_valid[i];
        owner_wdata = owner_wdata | req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef MEM_GRANT_FAIR_EN
  // Hide the previous owner only when someone else is waiting; a lone
  // requester must still be able to win again.
  assign others_valid = req_valid & ~last_owner;
  assign idle_request = (others_valid != '0) ? others_valid : req_valid;
`else
  assign idle_request = req_valid;
`endif

  assign arb_request = (state == IDLE) ? idle_request : '0;

  // Owner dropping valid simply stalls the burst; there is no abort path.
  assign mem_valid = (state == BUSY) && owner_valid;
  assign beat_fire = mem_valid && mem_ready;
  assign last_beat = (beat_cnt == len);
  assign req_ready = beat_fire ? owner : '0;

  assign mem_addr  = base + {{(AW-LW){1'b0}}, beat_cnt};
  assign mem_we    = we_q;
  assign mem_wdata = owner_wdata;
  assign busy      = (state == BUSY);

  // Burst sequencer. The exit on the final beat happens before beat_cnt
  // would increment, so len = all-ones never overflows the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      base     <= '0;
      len      <= '0;
      beat_cnt <= '0;
      we_q     <= 1'b0;
`ifdef MEM_GRANT_FAIR_EN
      last_owner <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_onehot) begin
            owner    <= arb_grant;
            base     <= grant_addr;
            len      <= grant_len;
            we_q     <= grant_we;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (beat_fire) begin
            if (last_beat) begin
              state <= IDLE;
              owner <= '0;
`ifdef MEM_GRANT_FAIR_EN
              last_owner <= owner;
`endif
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          owner <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_grant_sequencer
//
// Self-checking bench for mem_grant_sequencer. A behavioural reference model
// keeps the active burst as a queue of expected word addresses and compares
// every DUT output each cycle. A simple lowest-index-wins arbiter drives
// arb_grant, with an override to inject illegal grant vectors.
// Define MEM_GRANT_FAIR_EN for both bench and RTL to check the fair mode.
// ---------------------------------------------------------------------------
module tb_mem_grant_sequencer;

  localparam int N  = 10;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int EW = 3 + 3*N + AW + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_we;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      arb_request;
  logic [N-1:0]      arb_grant;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic [N-1:0]      owner;

  mem_grant_sequencer #(.N(N), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .arb_request (arb_request),
    .arb_grant   (arb_grant),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  // Arbiter: lowest set request bit wins, unless a forced grant is injected.
  bit           force_en;
  logic [N-1:0] force_val;
  assign arb_grant = force_en ? force_val : (arb_request & (~arb_request + 1'b1));

  // Requester side
  bit            pend [N];
  bit            drop [N];
  logic [AW-1:0] raddr [N];
  logic [LW-1:0] rlen [N];
  bit            rwe [N];
  logic [DW-1:0] rwd [N];
  bit            hold_wd;
  bit            refill;
  bit            force_len0;
  bit            ready_drv;

  // Reference model
  bit            m_busy;
  int            m_own;
  logic [AW-1:0] addr_q [$];
  bit            m_we;
  logic [N-1:0]  m_last;
  bit            m_take;
  int            m_take_idx;
  bit            m_acc;

  logic [EW-1:0] exp_vec;
  logic [EW-1:0] obs_vec;

  int total;
  int bad;

  function automatic void new_burst(input int i);
    pend[i]  = 1'b1;
    rwe[i]   = 1'($urandom);
    rlen[i]  = force_len0 ? '0 : LW'($urandom);
    if ($urandom_range(0, 3) == 0)
      raddr[i] = 32'hFFFF_FFF8 + AW'($urandom_range(0, 7));
    else
      raddr[i] = AW'($urandom);
  endfunction

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++) r = r | pend[i];
    return r;
  endfunction

  // Drive inputs, predict outputs from the model, sample at the falling edge.
  task automatic settle();
    logic [N-1:0]  e_arb;
    logic [N-1:0]  g;
    logic [N-1:0]  e_own;
    logic [N-1:0]  e_rr;
    logic          e_valid;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i] & ~drop[i];
      req_addr[i*AW +: AW] = raddr[i];
      req_len[i*LW +: LW]  = rlen[i];
      req_we[i] = rwe[i];
      if (!hold_wd) rwd[i] = DW'($urandom);
      req_wdata[i*DW +: DW] = rwd[i];
    end
    mem_ready = ready_drv;
    e_arb = '0; g = '0; e_own = '0; e_rr = '0;
    e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    m_take = 1'b0; m_acc = 1'b0;
    if (!m_busy) begin
      e_arb = req_valid;
`ifdef MEM_GRANT_FAIR_EN
      if ((req_valid & ~m_last) != '0) e_arb = req_valid & ~m_last;
`endif
      if (force_en) g = force_val;
      else begin
        for (int i = 0; i < N; i++) begin
          if (e_arb[i]) begin
            g[i] = 1'b1;
            break;
          end
        end
      end
      if ($countones(g) == 1) begin
        m_take = 1'b1;
        for (int i = 0; i < N; i++) if (g[i]) m_take_idx = i;
      end
    end else begin
      e_own[m_own] = 1'b1;
      e_valid = req_valid[m_own];
      e_addr  = addr_q[0];
      e_we    = m_we;
      e_wd    = rwd[m_own];
      m_acc   = e_valid && ready_drv;
      if (m_acc) e_rr = e_own;
    end
    @(negedge clk);
    exp_vec = {m_busy, e_valid, e_own, e_rr, e_arb, e_we, e_addr, e_wd};
    obs_vec = {busy, mem_valid, owner, req_ready, arb_request,
               m_busy ? mem_we : 1'b0,
               m_busy ? mem_addr : {AW{1'b0}},
               m_busy ? mem_wdata : {DW{1'b0}}};
  endtask

  // Move the model across the rising edge, then step off the edge.
  task automatic advance();
    @(posedge clk);
    if (!m_busy) begin
      if (m_take) begin
        m_busy = 1'b1;
        m_own  = m_take_idx;
        m_we   = rwe[m_take_idx];
        addr_q.delete();
        for (int b = 0; b <= int'(rlen[m_take_idx]); b++)
          addr_q.push_back(raddr[m_take_idx] + AW'(b));
      end
    end else if (m_acc) begin
      void'(addr_q.pop_front());
      if (addr_q.size() == 0) begin
        m_busy = 1'b0;
        m_last = '0;
        m_last[m_own] = 1'b1;
        if (refill) new_burst(m_own);
        else pend[m_own] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    addr_q.delete();
    m_last = '0;
  endtask

  task automatic drain(input string name);
    int c;
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    force_en = 1'b0; refill = 1'b0; ready_drv = 1'b1; hold_wd = 1'b0;
    c = 0;
    while ((m_busy || any_pend()) && c < 400) begin
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL %s_drain cycle %0d: got %h want %h", name, c, obs_vec, exp_vec);
      end
      advance();
      c++;
    end
    if (c >= 400) begin
      bad++;
      $display("[TB] FAIL %s_drain timeout: got busy after %0d cycles, want idle", name, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ready_drv = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'($urandom);
    for (int k = 0; k < 3; k++) begin
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL reset_state cycle %0d: got %h want %h", k, obs_vec, exp_vec);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) pend[i] = 1'($urandom);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    int pulses;
    pulses = 0;
    ready_drv = 1'b1;
    raddr[2] = 32'h100; rlen[2] = 4'd3; rwe[2] = 1'b1; pend[2] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      settle();
      if (req_ready[2] === 1'b1) pulses++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL single_burst cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    total++;
    if (pulses !== 4) begin
      bad++;
      $display("[TB] FAIL single_burst_pulses: got %0d want 4", pulses);
    end
    drain("single_burst");
  endtask

  task automatic test_priority();
    logic [N-1:0] seq [$];
    bit prev;
    prev = 1'b0;
    ready_drv = 1'b1;
    raddr[1] = AW'($urandom); rlen[1] = 4'd1; rwe[1] = 1'b0; pend[1] = 1'b1;
    raddr[3] = AW'($urandom); rlen[3] = 4'd2; rwe[3] = 1'b1; pend[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (busy === 1'b1 && !prev) seq.push_back(owner);
      prev = (busy === 1'b1);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL priority cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    total++;
    if (seq.size() != 2 || seq[0] !== 10'b00_0000_0010 || seq[1] !== 10'b00_0000_1000) begin
      bad++;
      $display("[TB] FAIL priority_order: got %0d bursts first %b, want 0000000010 then 0000001000",
               seq.size(), (seq.size() > 0) ? seq[0] : 10'b0);
    end
    drain("priority");
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    hold_wd = 1'b1;
    rwd[1] = 32'hCAFE_0001;
    raddr[1] = AW'($urandom); rlen[1] = 4'd1; rwe[1] = 1'b1; pend[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ready_drv = (c >= 4);
      settle();
      if (req_ready[1] === 1'b1) pulses++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL stall cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    total++;
    if (pulses !== 2) begin
      bad++;
      $display("[TB] FAIL stall_pulses: got %0d want 2", pulses);
    end
    drain("stall");
  endtask

  task automatic test_async_reset();
    int c;
    bit seen;
    ready_drv = 1'b1;
    raddr[5] = AW'($urandom); rlen[5] = 4'd3; rwe[5] = 1'b0; pend[5] = 1'b1;
    c = 0;
    while (!(m_busy && addr_q.size() == 2) && c < 20) begin
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL async_reset_pre cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
      c++;
    end
    total++;
    if (c >= 20) begin
      bad++;
      $display("[TB] FAIL async_reset_reach_beat2: got timeout want beat 2");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, mem_valid, owner, req_ready} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_immediate: got busy=%b valid=%b owner=%b ready=%b want all zero",
               busy, mem_valid, owner, req_ready);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (busy === 1'b1 && !seen) begin
        seen = 1'b1;
        total++;
        if (mem_addr !== raddr[5]) begin
          bad++;
          $display("[TB] FAIL async_reset_restart_addr: got %h want %h", mem_addr, raddr[5]);
        end
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL async_reset_post cycle %0d: got %h want %h", k, obs_vec, exp_vec);
      end
      advance();
    end
    drain("async_reset");
  endtask

  task automatic test_illegal_grant();
    ready_drv = 1'b1;
    raddr[0] = AW'($urandom); rlen[0] = 4'd0; pend[0] = 1'b1;
    raddr[1] = AW'($urandom); rlen[1] = 4'd0; pend[1] = 1'b1;
    force_en = 1'b1;
    force_val = 10'b00_0000_0011;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL illegal_grant cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    force_en = 1'b0;
    drain("illegal_grant");
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq [$];
    logic [N-1:0] want;
    bit prev;
    int c;
    prev = 1'b0;
    force_len0 = 1'b1;
    refill = 1'b1;
    ready_drv = 1'b1;
    new_burst(0);
    new_burst(4);
    c = 0;
    while (seq.size() < 4 && c < 40) begin
      settle();
      if (busy === 1'b1 && !prev) seq.push_back(owner);
      prev = (busy === 1'b1);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL fairness cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
      c++;
    end
    total++;
    if (seq.size() < 4) begin
      bad++;
      $display("[TB] FAIL fairness_bursts: got %0d want 4", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
`ifdef MEM_GRANT_FAIR_EN
      want = (k % 2 == 0) ? 10'b00_0000_0001 : 10'b00_0001_0000;
`else
      want = 10'b00_0000_0001;
`endif
      total++;
      if (seq[k] !== want) begin
        bad++;
        $display("[TB] FAIL fairness_owner %0d: got %b want %b", k, seq[k], want);
      end
    end
    force_len0 = 1'b0;
    drain("fairness");
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 9) == 0) new_burst(i);
        drop[i] = ($urandom_range(0, 9) == 0);
      end
      ready_drv = ($urandom_range(0, 9) < 7);
      force_en = 1'b0;
      if (!m_busy && $urandom_range(0, 19) == 0) begin
        force_val = N'($urandom);
        if ($countones(force_val) == 1) force_val = force_val | 10'b10_0000_0000 | 10'b00_0000_0001;
        force_en = 1'b1;
      end
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    drain("random");
  endtask

  initial begin
    total = 0; bad = 0;
    force_en = 1'b0; force_val = '0;
    hold_wd = 1'b0; refill = 1'b0; force_len0 = 1'b0; ready_drv = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; drop[i] = 1'b0; raddr[i] = '0;
      rlen[i] = '0; rwe[i] = 1'b0; rwd[i] = '0;
    end
    m_own = 0; m_we = 1'b0; m_take_idx = 0;
    model_reset();
    $display("[TB] starting mem_grant_sequencer bench");
    test_reset();
    test_single_burst();
    test_priority();
    test_stall();
    test_async_reset();
    test_illegal_grant();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
